// File: rtl/dm_responder.sv
`default_nettype none
// ============================================================================
// dm_responder : data-memory responder with programmable wait states and
//                little-endian byte/half/word load-store lanes.
// Revision     : 1.0
// ============================================================================
module dm_responder #(
  parameter int          DEPTH       = 4096,
  parameter logic [31:0] BASE        = 32'h0000_0000,
  parameter int          WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_wop,
  input  logic [2:0]  req_rop,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int                 c_addr_bits = $clog2(DEPTH);
  localparam int                 c_cnt_w     = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [c_cnt_w-1:0] c_cnt_last  = c_cnt_w'(WAIT_CYCLES);
  localparam logic [32:0]        c_limit     = 33'(DEPTH) << 2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [c_cnt_w-1:0]   r_cnt;
  logic                 w_accept;
  logic                 w_commit;

  logic                 r_we;
  logic [31:0]          r_addr;
  logic [31:0]          r_wdata;
  logic [1:0]           r_wop;
  logic [2:0]           r_rop;
  logic [31:0]          r_rdata;
  logic                 r_err;

  logic [31:0]          r_mem [DEPTH];

  logic [31:0]          w_off;
  logic                 w_oob;
  logic                 w_illegal;
  logic                 w_is_word;
  logic                 w_is_half;
  logic                 w_misalign;
  logic                 w_err;
  logic [c_addr_bits-1:0] w_idx;
  logic [31:0]          w_old;
  logic [7:0]           w_byte;
  logic [15:0]          w_half;
  logic [31:0]          w_load;
  logic [31:0]          w_new;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // WAIT spans WAIT_CYCLES+1 cycles so the response lands WAIT_CYCLES+1 edges after accept
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                       r_cnt <= '0;
    else if (r_state == S_WAIT && r_cnt != c_cnt_last) r_cnt <= r_cnt + 1'b1;
    else                                              r_cnt <= '0;
  end

  always_comb begin
    w_state_nxt = r_state;
    req_ready   = 1'b0;
    resp_valid  = 1'b0;
    w_accept    = 1'b0;
    w_commit    = 1'b0;
    case (r_state)
      S_IDLE: begin
        req_ready = 1'b1;
        w_accept  = req_valid;
        if (req_valid) w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (r_cnt == c_cnt_last) begin
          w_commit    = 1'b1;
          w_state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_wop   <= '0;
      r_rop   <= '0;
    end else if (w_accept) begin
      r_we    <= req_we;
      r_addr  <= req_addr;
      r_wdata <= req_wdata;
      r_wop   <= req_wop;
      r_rop   <= req_rop;
    end
  end

  // Request decode works on the captured request only
  assign w_off = r_addr - BASE;
  assign w_oob = (r_addr < BASE) || ({1'b0, w_off} >= c_limit);

  always_comb begin
    w_illegal = 1'b0;
    w_is_word = 1'b0;
    w_is_half = 1'b0;
    if (r_we) begin
      case (r_wop)
        2'd0:    w_is_word = 1'b1;
        2'd1:    w_is_half = 1'b1;
        2'd2:    w_illegal = 1'b0;
        default: w_illegal = 1'b1;
      endcase
    end else begin
      case (r_rop)
        3'd0:       w_is_word = 1'b1;
        3'd1, 3'd2: w_is_half = 1'b1;
        3'd3, 3'd4: w_illegal = 1'b0;
        default:    w_illegal = 1'b1;
      endcase
    end
  end

  assign w_misalign = (w_is_word && (w_off[1:0] != 2'b00)) || (w_is_half && w_off[0]);
  assign w_err      = w_oob | w_illegal | w_misalign;
  assign w_idx      = w_off[c_addr_bits+1:2];
  assign w_old      = r_mem[w_idx];
  assign w_byte     = w_old[{w_off[1:0], 3'b000} +: 8];
  assign w_half     = w_old[{w_off[1], 4'b0000} +: 16];

  always_comb begin
    case (r_rop)
      3'd1:    w_load = {{16{w_half[15]}}, w_half};
      3'd2:    w_load = {16'h0000, w_half};
      3'd3:    w_load = {{24{w_byte[7]}}, w_byte};
      3'd4:    w_load = {24'h00_0000, w_byte};
      default: w_load = w_old;
    endcase
  end

  // Sub-word stores merge into the current word so untouched lanes survive
  always_comb begin
    w_new = w_old;
    case (r_wop)
      2'd0:    w_new = r_wdata;
      2'd1:    w_new[{w_off[1], 4'b0000} +: 16] = r_wdata[15:0];
      default: w_new[{w_off[1:0], 3'b000} +: 8] = r_wdata[7:0];
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_commit && r_we && !w_err) r_mem[w_idx] <= w_new;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else if (w_commit) begin
      r_err   <= w_err;
      r_rdata <= (w_err || r_we) ? 32'h0 : w_load;
    end
  end

  assign resp_rdata = r_rdata;
  assign resp_err   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_dm_responder.sv
`default_nettype none
// tb_dm_responder : randomized scoreboard bench for dm_responder, checked
// against a byte-addressed memory model.
module tb_dm_responder;

  localparam int          DEPTH       = 4096;
  localparam logic [31:0] BASE        = 32'h0000_0000;
  localparam int          WAIT_CYCLES = 2;
  localparam int          BOUND       = 200;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [1:0]  req_wop = '0;
  logic [2:0]  req_rop = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_rdata;
  logic        resp_err;

  always #5 clk = ~clk;

  dm_responder #(
    .DEPTH       (DEPTH),
    .BASE        (BASE),
    .WAIT_CYCLES (WAIT_CYCLES)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_wop    (req_wop),
    .req_rop    (req_rop),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          acc;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] mb [int];
  int         errors = 0;
  int         checks = 0;
  int         cyc = 0;
  int         rr_mode = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: memory as individual bytes; loads assemble and extend arithmetically
  function automatic void model(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [1:0] wop, input logic [2:0] rop,
                                output logic [31:0] rdata, output logic err);
    longint off;
    longint v;
    int     size;
    bit     sgn;
    bit     bad;
    off  = longint'(addr) - longint'(BASE);
    bad  = 0;
    sgn  = 0;
    size = 1;
    if (we) begin
      case (wop)
        2'd0:    size = 4;
        2'd1:    size = 2;
        2'd2:    size = 1;
        default: bad = 1;
      endcase
    end else begin
      case (rop)
        3'd0: size = 4;
        3'd1: begin size = 2; sgn = 1; end
        3'd2: size = 2;
        3'd3: begin size = 1; sgn = 1; end
        3'd4: size = 1;
        default: bad = 1;
      endcase
    end
    if (off < 0 || off >= 4 * DEPTH || (off % size) != 0) bad = 1;
    rdata = 32'h0;
    err   = bad;
    if (bad) return;
    if (we) begin
      for (int i = 0; i < size; i++) mb[int'(off) + i] = wdata[8*i +: 8];
    end else begin
      v = 0;
      for (int i = 0; i < size; i++) v += longint'(mb[int'(off) + i]) << (8 * i);
      if (sgn && v[8*size-1]) v -= (longint'(1) << (8 * size));
      rdata = v[31:0];
    end
  endfunction

  task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [1:0] wop, input logic [2:0] rop, input bit track);
    exp_t e;
    int   n;
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_wop   = wop;
    req_rop   = rop;
    n = 0;
    while (!req_ready && n < BOUND) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      errors++;
      checks++;
      $display("FAIL accept_timeout: req_ready=%b after %0d cycles, expected 1", req_ready, n);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_we    = 1'($urandom_range(1));
    req_addr  = $urandom;
    req_wdata = $urandom;
    req_wop   = 2'($urandom_range(3));
    req_rop   = 3'($urandom_range(7));
    if (track) begin
      model(we, addr, wdata, wop, rop, e.rdata, e.err);
      e.acc = cyc;
      sb.push_back(e);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || resp_valid) && n < BOUND) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (sb.size() != 0 || resp_valid) begin
      errors++;
      $display("FAIL drain_timeout: pending=%0d resp_valid=%b, expected 0 and 0", sb.size(), resp_valid);
    end
  endtask

  initial begin : rr_drv
    forever begin
      @(posedge clk);
      #1;
      case (rr_mode)
        1:       resp_ready = 1'b0;
        2:       resp_ready = 1'b1;
        default: resp_ready = ($urandom_range(3) != 0);
      endcase
    end
  end

  initial begin : mon
    bit          was_valid;
    bit          pend_idle;
    int          first;
    logic [31:0] held_d;
    logic        held_e;
    exp_t        e;
    was_valid = 0;
    pend_idle = 0;
    first     = 0;
    held_d    = '0;
    held_e    = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        was_valid = 0;
        pend_idle = 0;
        continue;
      end
      if (pend_idle) begin
        chk("req_ready_after_resp", 32'(req_ready), 32'd1);
        pend_idle = 0;
      end
      if (resp_valid) begin
        chk("req_ready_in_resp", 32'(req_ready), 32'd0);
        if (!was_valid) first = cyc;
        else begin
          chk("rdata_stable", resp_rdata, held_d);
          chk("err_stable", 32'(resp_err), 32'(held_e));
        end
        held_d    = resp_rdata;
        held_e    = resp_err;
        was_valid = 1;
        if (resp_ready) begin
          if (sb.size() == 0) begin
            errors++;
            checks++;
            $display("FAIL unexpected_resp: rdata=%h err=%b with no request outstanding", resp_rdata, resp_err);
          end else begin
            e = sb.pop_front();
            chk("rdata", resp_rdata, e.rdata);
            chk("err", 32'(resp_err), 32'(e.err));
            chk("latency", 32'(first - e.acc), 32'(WAIT_CYCLES + 1));
          end
          was_valid = 0;
          pend_idle = 1;
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    logic [31:0] a;
    logic        w;
    logic [1:0]  wo;
    logic [2:0]  ro;
    int          n;

    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_rdata", resp_rdata, 32'h0);
    chk("rst_err", 32'(resp_err), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd1);

    // Known contents for the low 64 bytes
    for (int i = 0; i < 16; i++) issue(1'b1, BASE + 32'(4 * i), $urandom, 2'd0, 3'd0, 1'b1);

    issue(1'b1, 32'h10, 32'h8765_4321, 2'd0, 3'd0, 1'b1);
    issue(1'b0, 32'h10, 32'h0,         2'd0, 3'd0, 1'b1);
    issue(1'b1, 32'h11, 32'h0000_00AB, 2'd2, 3'd0, 1'b1);
    issue(1'b0, 32'h11, 32'h0,         2'd0, 3'd3, 1'b1);
    issue(1'b0, 32'h11, 32'h0,         2'd0, 3'd4, 1'b1);
    issue(1'b0, 32'h10, 32'h0,         2'd0, 3'd0, 1'b1);
    issue(1'b1, 32'h12, 32'h0000_1234, 2'd1, 3'd0, 1'b1);
    issue(1'b0, 32'h12, 32'h0,         2'd0, 3'd1, 1'b1);
    issue(1'b0, 32'h13, 32'h0,         2'd0, 3'd1, 1'b1);
    issue(1'b1, 32'h02, $urandom,      2'd0, 3'd0, 1'b1);
    issue(1'b0, 32'(4 * DEPTH), 32'h0, 2'd0, 3'd0, 1'b1);
    issue(1'b0, 32'h00, 32'h0,         2'd0, 3'd0, 1'b1);
    issue(1'b1, 32'h08, $urandom,      2'd3, 3'd0, 1'b1);
    issue(1'b0, 32'h08, 32'h0,         2'd0, 3'd5, 1'b1);
    drain();

    // Back-pressure: response must hold while resp_ready is low
    rr_mode = 1;
    issue(1'b0, 32'h10, 32'h0, 2'd0, 3'd0, 1'b1);
    n = 0;
    while (!resp_valid && n < BOUND) begin
      @(negedge clk);
      n++;
    end
    repeat (5) @(negedge clk);
    rr_mode = 2;
    drain();

    // Reset during WAIT discards an uncommitted store
    issue(1'b1, 32'h20, 32'hDEAD_BEEF, 2'd0, 3'd0, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("midrst_resp_valid", 32'(resp_valid), 32'd0);
    chk("midrst_rdata", resp_rdata, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_req_ready", 32'(req_ready), 32'd1);
    issue(1'b0, 32'h20, 32'h0, 2'd0, 3'd0, 1'b1);
    drain();
    rr_mode = 0;

    for (int k = 0; k < 80; k++) begin
      w  = 1'($urandom_range(1));
      wo = 2'($urandom_range(3));
      ro = 3'($urandom_range(5));
      case ($urandom_range(7))
        0:       a = 32'(4 * DEPTH) + 32'($urandom_range(15));
        1:       a = $urandom | 32'h8000_0000;
        default: a = 32'($urandom_range(63));
      endcase
      issue(w, a, $urandom, wo, ro, 1'b1);
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
